// File: rtl/gray_ptr_fifo_pkg.sv
// gcfifo_pkg: shared Gray-code helpers for the Gray-pointer FIFO slice.
// Holds the 3-bit Gray sequence constants, the default pointer type and
// bin2gray / gray2bin conversions usable at any width up to GCFIFO_FN_W.
package gcfifo_pkg;

  // Widest value the conversion functions handle. Callers zero-extend their
  // operand into the function and size-cast the result back to their width.
  localparam int GCFIFO_FN_W = 32;

  // The 3-bit reflected Gray sequence, in counting order.
  localparam logic [2:0] GRAY0 = 3'b000;
  localparam logic [2:0] GRAY1 = 3'b001;
  localparam logic [2:0] GRAY2 = 3'b011;
  localparam logic [2:0] GRAY3 = 3'b010;
  localparam logic [2:0] GRAY4 = 3'b110;
  localparam logic [2:0] GRAY5 = 3'b111;
  localparam logic [2:0] GRAY6 = 3'b101;
  localparam logic [2:0] GRAY7 = 3'b100;

  // Pointer for the default depth of 8 entries (AW=3, one wrap bit).
  typedef logic [3:0] gptr_t;

  // Binary to Gray. Zero-extended inputs give the right answer for any
  // narrower width because the extra high bits stay zero.
  function automatic logic [GCFIFO_FN_W-1:0] bin2gray(input logic [GCFIFO_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GCFIFO_FN_W-1:0] gray2bin(input logic [GCFIFO_FN_W-1:0] g);
    logic [GCFIFO_FN_W-1:0] b;
    b[GCFIFO_FN_W-1] = g[GCFIFO_FN_W-1];
    for (int i = GCFIFO_FN_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_fifo_if.sv
// gray_ptr_fifo_if: write/read handshake, flags and exported Gray pointers
// of the Gray-pointer FIFO. The level/almost_full pair only exists when
// GRAY_PTR_FIFO_LEVEL_EN is defined.
interface gray_ptr_fifo_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          wr_err;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          rd_err;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
`ifdef GRAY_PTR_FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

`ifdef GRAY_PTR_FIFO_LEVEL_EN
  modport master (
    output wr_en, wr_data, rd_en,
    input  full, wr_err, rd_data, rd_valid, empty, rd_err,
    input  wr_ptr_gray, rd_ptr_gray, level, almost_full
  );
  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, wr_err, rd_data, rd_valid, empty, rd_err,
    output wr_ptr_gray, rd_ptr_gray, level, almost_full
  );
`else
  modport master (
    output wr_en, wr_data, rd_en,
    input  full, wr_err, rd_data, rd_valid, empty, rd_err,
    input  wr_ptr_gray, rd_ptr_gray
  );
  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, wr_err, rd_data, rd_valid, empty, rd_err,
    output wr_ptr_gray, rd_ptr_gray
  );
`endif

endinterface

// File: rtl/gray_ptr_fifo_gray_ptr.sv
// gray_ptr: (AW+1)-bit Gray-coded pointer register. Advances by one Gray
// step when i_inc is high, so exactly one bit changes per increment and the
// value wraps from the top Gray code back to zero.
module gray_ptr
  import gcfifo_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [AW:0] o_gray
);

  localparam int PW = AW + 1;

  logic [AW:0] r_gray;
  logic [AW:0] w_bin_nxt;
  logic [AW:0] w_gray_nxt;

  // Next Gray value: decode, add one modulo 2**PW, re-encode. The binary sum
  // is truncated to PW bits before encoding so the wrap lands on zero.
  always_comb begin
    w_bin_nxt  = PW'(gray2bin(GCFIFO_FN_W'(r_gray)) + 32'd1);
    w_gray_nxt = PW'(bin2gray(GCFIFO_FN_W'(w_bin_nxt)));
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gray <= '0;
    end else if (i_inc) begin
      r_gray <= w_gray_nxt;
    end
  end

  assign o_gray = r_gray;

endmodule

// File: rtl/gray_ptr_fifo.sv
// gray_ptr_fifo: single-clock FIFO of 2**AW words whose write and read
// pointers are Gray counters. Full/empty come straight from comparing the
// Gray pointers; both pointers are exported for a later dual-clock variant.
// Optional build macro GRAY_PTR_FIFO_LEVEL_EN adds level and almost_full.
// AW must be at least 2 (the full test inspects the top two pointer bits).
module gray_ptr_fifo
  import gcfifo_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  gray_ptr_fifo_if.slave  bus
);

  localparam int PW    = AW + 1;
  localparam int DEPTH = 2 ** AW;

  logic [AW:0]   w_wr_ptr;
  logic [AW:0]   w_rd_ptr;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic          r_wr_err;
  logic          r_rd_err;

  gray_ptr #(.AW(AW)) u_wr_ptr (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_wr_acc),
    .o_gray (w_wr_ptr)
  );

  gray_ptr #(.AW(AW)) u_rd_ptr (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_rd_acc),
    .o_gray (w_rd_ptr)
  );

  // Flags straight from the Gray pointers. Full means the write pointer is
  // exactly one lap ahead: in Gray code that flips the top two bits.
  always_comb begin
    w_empty   = (w_wr_ptr == w_rd_ptr);
    w_full    = (w_wr_ptr == {~w_rd_ptr[AW:AW-1], w_rd_ptr[AW-2:0]});
    w_wr_acc  = bus.wr_en && !w_full;
    w_rd_acc  = bus.rd_en && !w_empty;
    w_wr_addr = AW'(gray2bin(GCFIFO_FN_W'(w_wr_ptr)));
    w_rd_addr = AW'(gray2bin(GCFIFO_FN_W'(w_rd_ptr)));
  end

  // Storage array; contents survive reset and are only overwritten by writes.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= bus.wr_data;
    end
  end

  // Registered read port: captures the head word on an accepted read and
  // holds it otherwise. No write-to-read bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_rd_acc) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  // Read-valid and one-cycle error pulses for rejected requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_wr_err   <= bus.wr_en && w_full;
      r_rd_err   <= bus.rd_en && w_empty;
    end
  end

  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.wr_err      = r_wr_err;
  assign bus.rd_err      = r_rd_err;
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.wr_ptr_gray = w_wr_ptr;
  assign bus.rd_ptr_gray = w_rd_ptr;

`ifdef GRAY_PTR_FIFO_LEVEL_EN
  logic [AW:0] w_level;

  // Occupancy from the decoded pointers; modulo 2**PW handles the wrap.
  always_comb begin
    w_level = PW'(gray2bin(GCFIFO_FN_W'(w_wr_ptr)) - gray2bin(GCFIFO_FN_W'(w_rd_ptr)));
  end

  assign bus.level       = w_level;
  assign bus.almost_full = (w_level >= PW'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// tb_gray_ptr_fifo: randomized and directed stimulus against a queue-based
// reference FIFO. Accepted reads push their expected word into a scoreboard
// queue; a negedge monitor pops it when rd_valid shows and also checks flags,
// error pulses, pointer values and single-bit pointer steps every cycle.
module tb_gray_ptr_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_ptr_fifo_if #(.DW(DW), .AW(AW)) bus ();

  gray_ptr_fifo #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: FIFO contents, pointer step counts, expected pulses.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int m_wcnt = 0;
  int m_rcnt = 0;
  bit m_rvalid = 0;
  bit m_werr = 0;
  bit m_rerr = 0;

  logic [AW:0] prev_w = '0;
  logic [AW:0] prev_r = '0;
  bit wrap_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Reference model: a plain queue of words plus modulo-16 pointer counts.
  always @(posedge clk or posedge rst) begin : model
    bit wacc;
    bit racc;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_wcnt   = 0;
      m_rcnt   = 0;
      m_rvalid = 0;
      m_werr   = 0;
      m_rerr   = 0;
    end else begin
      wacc     = bus.wr_en && (mq.size() < DEPTH);
      racc     = bus.rd_en && (mq.size() > 0);
      m_werr   = bus.wr_en && !wacc;
      m_rerr   = bus.rd_en && !racc;
      m_rvalid = racc;
      if (racc) begin
        exp_q.push_back(mq.pop_front());
        m_rcnt = (m_rcnt + 1) % 16;
      end
      if (wacc) begin
        mq.push_back(bus.wr_data);
        m_wcnt = (m_wcnt + 1) % 16;
      end
    end
  end

  // Monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    chk("empty",    bus.empty,    32'(mq.size() == 0));
    chk("full",     bus.full,     32'(mq.size() == DEPTH));
    chk("wr_err",   bus.wr_err,   32'(m_werr));
    chk("rd_err",   bus.rd_err,   32'(m_rerr));
    chk("rd_valid", bus.rd_valid, 32'(m_rvalid));
    chk("wr_ptr",   bus.wr_ptr_gray, gray_of(m_wcnt));
    chk("rd_ptr",   bus.rd_ptr_gray, gray_of(m_rcnt));
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_data: got 0x%0h expected no word at %0t", bus.rd_data, $time);
      end else begin
        chk("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end
`ifdef GRAY_PTR_FIFO_LEVEL_EN
    chk("level",       bus.level,       mq.size());
    chk("almost_full", bus.almost_full, 32'(mq.size() >= DEPTH - 1));
`endif
    if (!rst) begin
      chk("wr_step_1bit", 32'($countones(bus.wr_ptr_gray ^ prev_w) <= 1), 1);
      chk("rd_step_1bit", 32'($countones(bus.rd_ptr_gray ^ prev_r) <= 1), 1);
      if (prev_w == 4'b1000 && bus.wr_ptr_gray == 4'b0000) wrap_seen = 1;
    end
    prev_w = bus.wr_ptr_gray;
    prev_r = bus.rd_ptr_gray;
  end

  task automatic step(input bit we, input logic [DW-1:0] d, input bit re);
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int depth;
    int op;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_empty",    bus.empty,       1);
    chk("rst_full",     bus.full,        0);
    chk("rst_wr_ptr",   bus.wr_ptr_gray, 0);
    chk("rst_rd_ptr",   bus.rd_ptr_gray, 0);
    chk("rst_rd_valid", bus.rd_valid,    0);
    step(0, 0, 0);

    // Fill with 0x01..0x08, then one rejected write
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0);
    chk("full_after_8", bus.full, 1);
    chk("wr_ptr_full",  bus.wr_ptr_gray, 4'b1100);
    step(1, 8'h09, 0);
    chk("wr_err_pulse",    bus.wr_err, 1);
    chk("wr_ptr_held",     bus.wr_ptr_gray, 4'b1100);
    step(0, 0, 0);
    chk("wr_err_one_cyc",  bus.wr_err, 0);

    // Drain, then one rejected read
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    chk("last_rd_data",   bus.rd_data, 8'h08);
    chk("empty_drained",  bus.empty, 1);
    step(0, 0, 1);
    chk("rd_err_pulse",   bus.rd_err, 1);
    chk("rd_valid_rej",   bus.rd_valid, 0);
    step(0, 0, 0);

    // Full with simultaneous read and write
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0);
    step(1, 8'hAA, 1);
    chk("full_sim_wr_err",   bus.wr_err, 1);
    chk("full_sim_full_clr", bus.full, 0);
    chk("full_sim_rd_valid", bus.rd_valid, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    step(0, 0, 0);

    // Empty with simultaneous read and write
    step(1, 8'h55, 1);
    chk("empty_sim_rd_err",   bus.rd_err, 1);
    chk("empty_sim_not_empty", bus.empty, 0);
    chk("empty_sim_no_bypass", bus.rd_valid, 0);
    step(0, 0, 1);
    chk("empty_sim_data", bus.rd_data, 8'h55);
    step(0, 0, 0);

    // Level / almost_full
    for (int i = 0; i < 7; i++) step(1, 8'($urandom), 0);
`ifdef GRAY_PTR_FIFO_LEVEL_EN
    chk("level_7", bus.level, 7);
    chk("af_7",    bus.almost_full, 1);
`endif
    step(0, 0, 1);
    step(0, 0, 1);
`ifdef GRAY_PTR_FIFO_LEVEL_EN
    chk("level_5", bus.level, 5);
    chk("af_5",    bus.almost_full, 0);
`endif
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(0, 0, 0);

    // Wrap: shallow random write/read mix held at depth 1..3
    step(1, 8'($urandom), 0);
    step(1, 8'($urandom), 0);
    depth = 2;
    for (int i = 0; i < 48; i++) begin
      op = int'($urandom_range(0, 2));
      if (op == 1 && depth < 3) begin
        step(1, 8'($urandom), 0);
        depth++;
      end else if (op == 2 && depth > 1) begin
        step(0, 0, 1);
        depth--;
      end else begin
        step(1, 8'($urandom), 1);
      end
    end
    while (depth > 0) begin
      step(0, 0, 1);
      depth--;
    end
    step(0, 0, 0);

    // Unconstrained random traffic, including rejected requests
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a write burst
    for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty",    bus.empty,       1);
    chk("arst_full",     bus.full,        0);
    chk("arst_wr_ptr",   bus.wr_ptr_gray, 0);
    chk("arst_rd_ptr",   bus.rd_ptr_gray, 0);
    chk("arst_rd_valid", bus.rd_valid,    0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);

    chk("wr_wrap_seen",  32'(wrap_seen), 1);
    chk("sb_drained",    exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
